// File: rtl/alu_rs.sv
// alu_rs: reservation station and issue stage for the integer ALU.
// Holds dispatched micro-ops in an age-ordered collapsing queue, with the
// oldest entry at index 0. Entries wake up from CDB broadcasts, and the
// oldest ready entry moves into a registered valid/ready issue slot.
module alu_rs #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int FUNC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              disp_valid_i,
  output logic              disp_ready_o,
  input  logic [FUNC_W-1:0] disp_func_i,
  input  logic [TAG_W-1:0]  disp_tag_i,
  input  logic              disp_src1_rdy_i,
  input  logic [WIDTH-1:0]  disp_src1_val_i,
  input  logic [TAG_W-1:0]  disp_src1_tag_i,
  input  logic              disp_src2_rdy_i,
  input  logic [WIDTH-1:0]  disp_src2_val_i,
  input  logic [TAG_W-1:0]  disp_src2_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [WIDTH-1:0]  cdb_value_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [WIDTH-1:0]  issue_op1_o,
  output logic [WIDTH-1:0]  issue_op2_o,
  output logic [FUNC_W-1:0] issue_func_o,
  output logic [TAG_W-1:0]  issue_tag_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              busy;
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  tag;
    logic              rdy1;
    logic [WIDTH-1:0]  val1;
    logic [TAG_W-1:0]  tag1;
    logic              rdy2;
    logic [WIDTH-1:0]  val2;
    logic [TAG_W-1:0]  tag2;
  } entry_t;

  entry_t            ent      [DEPTH];
  entry_t            woke     [DEPTH];
  entry_t            ent_next [DEPTH];
  entry_t            incoming;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  tail;
  logic [DEPTH-1:0]  ready_vec;
  logic              any_ready;
  logic [IDX_W-1:0]  sel_idx;
  logic              slot_free;
  logic              do_issue;
  logic              do_disp;

  // Dispatch acceptance uses registered count only, so a same-cycle issue does not open a slot.
  assign disp_ready_o = (count < CNT_W'(DEPTH));
  assign do_disp      = disp_valid_i & disp_ready_o;
  assign slot_free    = ~issue_valid_o | issue_ready_i;
  assign do_issue     = slot_free & any_ready;

  // Oldest-first select, using pre-wakeup state so a woken entry waits one cycle.
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = ent[i].busy & ent[i].rdy1 & ent[i].rdy2;
      if (!any_ready && ready_vec[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // CDB wakeup of resident entries: capture the value for any waiting source with a matching tag.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent[i];
      if (cdb_valid_i && ent[i].busy && !ent[i].rdy1 && ent[i].tag1 == cdb_tag_i) begin
        woke[i].rdy1 = 1'b1;
        woke[i].val1 = cdb_value_i;
      end
      if (cdb_valid_i && ent[i].busy && !ent[i].rdy2 && ent[i].tag2 == cdb_tag_i) begin
        woke[i].rdy2 = 1'b1;
        woke[i].val2 = cdb_value_i;
      end
    end
  end

  // Build the incoming entry, bypassing a same-cycle CDB broadcast into waiting sources.
  always_comb begin
    incoming      = '0;
    incoming.busy = 1'b1;
    incoming.func = disp_func_i;
    incoming.tag  = disp_tag_i;
    incoming.rdy1 = disp_src1_rdy_i;
    incoming.val1 = disp_src1_val_i;
    incoming.tag1 = disp_src1_tag_i;
    incoming.rdy2 = disp_src2_rdy_i;
    incoming.val2 = disp_src2_val_i;
    incoming.tag2 = disp_src2_tag_i;
    if (!disp_src1_rdy_i && cdb_valid_i && disp_src1_tag_i == cdb_tag_i) begin
      incoming.rdy1 = 1'b1;
      incoming.val1 = cdb_value_i;
    end
    if (!disp_src2_rdy_i && cdb_valid_i && disp_src2_tag_i == cdb_tag_i) begin
      incoming.rdy2 = 1'b1;
      incoming.val2 = cdb_value_i;
    end
  end

  // Collapse out the issued entry, then append the dispatched entry at the new tail.
  always_comb begin
    tail       = count - CNT_W'(do_issue);
    count_next = count + CNT_W'(do_disp) - CNT_W'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_next[i] = woke[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_issue && IDX_W'(i) >= sel_idx) begin
        ent_next[i] = woke[i + 1];
      end
    end
    if (do_issue) begin
      ent_next[DEPTH - 1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && tail == CNT_W'(i)) begin
        ent_next[i] = incoming;
      end
    end
  end

  // Station storage and occupancy count; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (flush_i) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      count <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= ent_next[i];
      end
    end
  end

  // Issue slot: load the selected entry when free, drain when accepted, hold while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_valid_o <= 1'b0;
      issue_op1_o   <= '0;
      issue_op2_o   <= '0;
      issue_func_o  <= '0;
      issue_tag_o   <= '0;
    end else if (flush_i) begin
      issue_valid_o <= 1'b0;
    end else if (do_issue) begin
      issue_valid_o <= 1'b1;
      issue_op1_o   <= ent[sel_idx].val1;
      issue_op2_o   <= ent[sel_idx].val2;
      issue_func_o  <= ent[sel_idx].func;
      issue_tag_o   <= ent[sel_idx].tag;
    end else if (issue_ready_i) begin
      issue_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs, with a scoreboard of expected issued ops.
module tb_alu_rs;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        disp_valid_i;
  logic        disp_ready_o;
  logic [3:0]  disp_func_i;
  logic [3:0]  disp_tag_i;
  logic        disp_src1_rdy_i;
  logic [31:0] disp_src1_val_i;
  logic [3:0]  disp_src1_tag_i;
  logic        disp_src2_rdy_i;
  logic [31:0] disp_src2_val_i;
  logic [3:0]  disp_src2_tag_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_value_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_op1_o;
  logic [31:0] issue_op2_o;
  logic [3:0]  issue_func_o;
  logic [3:0]  issue_tag_o;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [71:0] sbQueue[$];

  alu_rs #(.WIDTH(32), .DEPTH(4), .TAG_W(4), .FUNC_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_func_i(disp_func_i), .disp_tag_i(disp_tag_i),
    .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src1_val_i(disp_src1_val_i),
    .disp_src1_tag_i(disp_src1_tag_i),
    .disp_src2_rdy_i(disp_src2_rdy_i), .disp_src2_val_i(disp_src2_val_i),
    .disp_src2_tag_i(disp_src2_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_op1_o(issue_op1_o), .issue_op2_o(issue_op2_o),
    .issue_func_o(issue_func_o), .issue_tag_o(issue_tag_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [71:0] packOp(input logic [3:0] func, input logic [3:0] tag,
                                         input logic [31:0] op1, input logic [31:0] op2);
    return {func, tag, op1, op2};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one dispatch for a single clock edge.
  task automatic applyStimulus(input logic [3:0] func, input logic [3:0] tag,
                               input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                               input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    disp_func_i     = func;
    disp_tag_i      = tag;
    disp_src1_rdy_i = r1;
    disp_src1_val_i = v1;
    disp_src1_tag_i = t1;
    disp_src2_rdy_i = r2;
    disp_src2_val_i = v2;
    disp_src2_tag_i = t2;
    disp_valid_i    = 1'b1;
    tick();
    disp_valid_i    = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] tag, input logic [31:0] value);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = tag;
    cdb_value_i = value;
    tick();
    cdb_valid_i = 1'b0;
  endtask

  // Scoreboard side: every accepted issue must match the oldest expected op.
  always @(negedge clk_i) begin
    if (rst_ni && !flush_i && issue_valid_o && issue_ready_i) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_issue", {68'd0, issue_tag_o}, 72'hFFFF);
      end else begin
        checkOutput("issue_op", packOp(issue_func_o, issue_tag_o, issue_op1_o, issue_op2_o),
                    sbQueue.pop_front());
      end
    end
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; disp_valid_i = 1'b0;
    disp_func_i = '0; disp_tag_i = '0;
    disp_src1_rdy_i = 1'b0; disp_src1_val_i = '0; disp_src1_tag_i = '0;
    disp_src2_rdy_i = 1'b0; disp_src2_val_i = '0; disp_src2_tag_i = '0;
    cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_value_i = '0;
    issue_ready_i = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_issue_valid", {71'd0, issue_valid_o}, 72'd0);
    checkOutput("rst_issue_fields", packOp(issue_func_o, issue_tag_o, issue_op1_o, issue_op2_o), 72'd0);
    #10 rst_ni = 1'b1;
    tick();
    checkOutput("rst_disp_ready", {71'd0, disp_ready_o}, 72'd1);

    // Test 1: ready op issues two cycles after dispatch
    sbQueue.push_back(packOp(4'd0, 4'd3, 32'd5, 32'd7));
    applyStimulus(4'd0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    checkOutput("t1_not_yet", {71'd0, issue_valid_o}, 72'd0);
    checkOutput("t1_ready_a", {71'd0, disp_ready_o}, 72'd1);
    tick();
    checkOutput("t1_valid", {71'd0, issue_valid_o}, 72'd1);
    checkOutput("t1_fields", packOp(issue_func_o, issue_tag_o, issue_op1_o, issue_op2_o),
                packOp(4'd0, 4'd3, 32'd5, 32'd7));
    checkOutput("t1_ready_b", {71'd0, disp_ready_o}, 72'd1);
    tick();
    checkOutput("t1_drain", {71'd0, issue_valid_o}, 72'd0);

    // Test 2: wakeup from CDB, issue the cycle after the capture edge
    applyStimulus(4'd1, 4'd4, 1'b0, 32'd0, 4'd9, 1'b1, 32'd2, 4'd0);
    tick();
    checkOutput("t2_waiting", {71'd0, issue_valid_o}, 72'd0);
    sbQueue.push_back(packOp(4'd1, 4'd4, 32'h10, 32'd2));
    broadcast(4'd9, 32'h10);
    checkOutput("t2_no_same_cycle", {71'd0, issue_valid_o}, 72'd0);
    tick();
    checkOutput("t2_valid", {71'd0, issue_valid_o}, 72'd1);
    checkOutput("t2_op1", {40'd0, issue_op1_o}, 72'h10);
    tick();

    // Test 3: fill, out-of-order wakeup, stall then release
    issue_ready_i = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      applyStimulus(4'(t), 4'(t), 1'b0, 32'd0, 4'(t + 4), 1'b0, 32'd0, 4'(t + 8));
      checkOutput("t3_disp_ready", {71'd0, disp_ready_o}, (t == 4) ? 72'd0 : 72'd1);
    end
    sbQueue.push_back(packOp(4'd3, 4'd3, 32'h70, 32'hB0));
    broadcast(4'd7, 32'h70);
    broadcast(4'd11, 32'hB0);
    tick();
    checkOutput("t3_first_tag3", packOp(issue_func_o, issue_tag_o, issue_op1_o, issue_op2_o),
                packOp(4'd3, 4'd3, 32'h70, 32'hB0));
    sbQueue.push_back(packOp(4'd1, 4'd1, 32'h50, 32'h90));
    broadcast(4'd5, 32'h50);
    broadcast(4'd9, 32'h90);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t3_stall_hold", packOp(issue_func_o, issue_tag_o, issue_op1_o, issue_op2_o),
                  packOp(4'd3, 4'd3, 32'h70, 32'hB0));
      checkOutput("t3_stall_valid", {71'd0, issue_valid_o}, 72'd1);
    end
    issue_ready_i = 1'b1;
    tick();
    checkOutput("t3_then_tag1", {68'd0, issue_tag_o}, 72'd1);
    tick();
    checkOutput("t3_empty_slot", {71'd0, issue_valid_o}, 72'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // Test 4: dispatch bypass of a same-cycle CDB broadcast
    cdb_valid_i = 1'b1; cdb_tag_i = 4'd6; cdb_value_i = 32'hAB;
    sbQueue.push_back(packOp(4'd2, 4'd5, 32'hAB, 32'd3));
    applyStimulus(4'd2, 4'd5, 1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0);
    cdb_valid_i = 1'b0;
    tick();
    checkOutput("t4_valid", {71'd0, issue_valid_o}, 72'd1);
    checkOutput("t4_op1", {40'd0, issue_op1_o}, 72'hAB);
    tick();

    // Test 5: flush with a full station and a concurrent dispatch
    issue_ready_i = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      applyStimulus(4'(t), 4'(t), 1'b0, 32'd0, 4'(t + 4), 1'b0, 32'd0, 4'(t + 8));
    end
    checkOutput("t5_full", {71'd0, disp_ready_o}, 72'd0);
    flush_i = 1'b1;
    applyStimulus(4'd7, 4'd7, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    flush_i = 1'b0;
    checkOutput("t5_flush_valid", {71'd0, issue_valid_o}, 72'd0);
    checkOutput("t5_flush_ready", {71'd0, disp_ready_o}, 72'd1);
    issue_ready_i = 1'b1;
    broadcast(4'd5, 32'h5);
    broadcast(4'd9, 32'h9);
    tick();
    tick();
    checkOutput("t5_dropped", {71'd0, issue_valid_o}, 72'd0);

    // Test 7: age-ordered select with a younger ready op overtaking a waiting one
    applyStimulus(4'd4, 4'd13, 1'b0, 32'd0, 4'd14, 1'b1, 32'h33, 4'd0);
    sbQueue.push_back(packOp(4'd5, 4'd10, 32'hA1, 32'hA2));
    applyStimulus(4'd5, 4'd10, 1'b1, 32'hA1, 4'd0, 1'b1, 32'hA2, 4'd0);
    sbQueue.push_back(packOp(4'd6, 4'd11, 32'hB1, 32'hB2));
    applyStimulus(4'd6, 4'd11, 1'b1, 32'hB1, 4'd0, 1'b1, 32'hB2, 4'd0);
    sbQueue.push_back(packOp(4'd4, 4'd13, 32'hCC, 32'h33));
    broadcast(4'd14, 32'hCC);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("t7_drained", {71'd0, issue_valid_o}, 72'd0);

    // Test 6: asynchronous reset mid-cycle while the slot is valid
    issue_ready_i = 1'b0;
    applyStimulus(4'd8, 4'd8, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    tick();
    checkOutput("t6_pre_valid", {71'd0, issue_valid_o}, 72'd1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("t6_async_valid", {71'd0, issue_valid_o}, 72'd0);
    checkOutput("t6_async_fields", packOp(issue_func_o, issue_tag_o, issue_op1_o, issue_op2_o), 72'd0);
    #2 rst_ni = 1'b1;
    tick();
    checkOutput("t6_post_ready", {71'd0, disp_ready_o}, 72'd1);

    checkOutput("sb_empty", 72'(sbQueue.size()), 72'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station and issue stage that feeds the integer ALU.
- Holds dispatched ALU micro-ops until both source operands are available, capturing operands broadcast on the common data bus (CDB).
- Selects the oldest ready entry and delivers it through a registered valid/ready issue slot to the ALU's op1/op2/func inputs, along with the destination tag.

Parameters:
- WIDTH, 32, operand/data width.
- DEPTH, 4, number of station entries (>=2).
- TAG_W, 4, physical/ROB tag width.
- FUNC_W, 4, ALU function code width (matches ALU_OP_* encoding).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  squash all entries and the issue slot.
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  station can accept a dispatch.
- disp_func_i  in  FUNC_W  ALU function code.
- disp_tag_i  in  TAG_W  destination tag.
- disp_src1_rdy_i  in  1  src1 value valid.
- disp_src1_val_i  in  WIDTH  src1 value.
- disp_src1_tag_i  in  TAG_W  src1 producer tag.
- disp_src2_rdy_i  in  1  src2 value valid.
- disp_src2_val_i  in  WIDTH  src2 value (immediates dispatched as ready).
- disp_src2_tag_i  in  TAG_W  src2 producer tag.
- cdb_valid_i  in  1  CDB broadcast valid.
- cdb_tag_i  in  TAG_W  CDB tag.
- cdb_value_i  in  WIDTH  CDB value.
- issue_valid_o  out  1  issue slot holds an op.
- issue_ready_i  in  1  ALU accepts the op.
- issue_op1_o  out  WIDTH  operand 1.
- issue_op2_o  out  WIDTH  operand 2.
- issue_func_o  out  FUNC_W  function code.
- issue_tag_o  out  TAG_W  destination tag.

Behaviour:

Entry storage:
- Each entry holds: busy, func, tag, and for each source a rdy/val/tag triple.
- Entries are kept age-ordered in a collapsing queue: index 0 is the oldest.
- Count ranges 0..DEPTH.

Reset (rst_ni=0, asynchronous):
- All busy bits cleared, count=0.
- issue_valid_o=0; issue_op1_o, issue_op2_o, issue_func_o and issue_tag_o all 0.
- disp_ready_o=1 once reset is released.

Dispatch:
- disp_ready_o = (count < DEPTH), derived from registered state only; it does not anticipate a same-cycle issue.
- A handshake (disp_valid_i & disp_ready_o) writes a new entry at the tail at the clock edge.

Wakeup:
- Every cycle, each busy entry whose source has rdy=0 and tag==cdb_tag_i, with cdb_valid_i=1, captures cdb_value_i and sets rdy=1 at the edge.
- Dispatch bypass: an incoming non-ready source whose tag matches a same-cycle CDB broadcast is written already ready with cdb_value_i.
- No same-cycle wakeup-to-select: an entry woken at edge N is first eligible for selection in cycle N+1.

Select and issue:
- An entry is ready when busy & src1.rdy & src2.rdy; the lowest-index ready entry is selected.
- The issue slot loads when (!issue_valid_o | issue_ready_i) and a ready entry exists.
- On load, the selected entry is removed and the entries above it shift down one index; simultaneous dispatch appends after the compaction.
- If the slot is free-able (issue_ready_i=1) but no entry is ready, issue_valid_o falls to 0.
- While issue_valid_o=1 & issue_ready_i=0, all issue outputs hold stable.

Latency:
- Minimum dispatch to issue_valid_o=1 is 2 cycles (dispatch at edge N, selection in cycle N+1, issue slot valid from edge N+1).
- Sustained throughput is 1 op/cycle while issue_ready_i=1.

Full condition:
- Count is DEPTH with simultaneous issue: disp_ready_o is still 0 that cycle, so no dispatch is accepted.
- Count returns to DEPTH-1 after the edge.

Simultaneous events:
- Dispatch and issue in the same cycle: count is unchanged.
- CDB matching both sources of one entry: both are captured.
- CDB matching an entry that is issuing the same cycle: that entry is already ready, so the broadcast is ignored.

Flush:
- flush_i=1 clears all busy bits and issue_valid_o at the edge.
- Flush dominates same-cycle dispatch, wakeup and issue.

Mid-operation reset: asynchronous; the station is cleared immediately regardless of state.

Arithmetic: no arithmetic on operands; values pass through unmodified at WIDTH bits.

Test Plan:
1. Reset, then dispatch func=ADD, tag=3, src1 rdy val=5, src2 rdy val=7 -> issue_valid_o=1 two cycles later with op1=5, op2=7, tag=3; disp_ready_o=1 throughout.
2. Dispatch tag=4 with src1 waiting on tag 9 and src2 ready val=2; later broadcast cdb tag=9 value=0x10 -> issue occurs the cycle after the CDB edge with op1=0x10, op2=2.
3. Dispatch tags 1,2,3,4 with all sources waiting, while issue_ready_i=0 -> disp_ready_o=0 after the 4th dispatch. Wake tag 3's sources, then tag 1's -> tag 3 issues first; then hold issue_ready_i=0 for 3 cycles -> outputs stable; release -> tag 1 follows.
4. Dispatch with a source tag equal to a same-cycle CDB broadcast (tag 6, value 0xAB) -> entry issues with operand 0xAB without any further broadcast.
5. With the station full, assert flush_i together with disp_valid_i -> next cycle count=0, issue_valid_o=0, disp_ready_o=1, and the dispatched op is dropped.
6. Assert rst_ni=0 mid-cycle while issue_valid_o=1 -> issue_valid_o drops to 0 immediately without waiting for a clock edge.
